alu_seq: RTL
============

# alu_seq

Sequential, parametrised successor to the processor's combinational ALU. It accepts one operation at a time over a valid/ready handshake. Single-cycle operations finish in one clock; the multiply is iterative and takes LEN cycles. Result and NZCV flags are registered and held until the consumer (register-file writeback) accepts them.

## Interface
- LEN, 32: operand/result width; power of two, ≥8
- SHW, log2(LEN): width of the shift-amount field taken from b[SHW-1:0]
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- opcd  in  4  operation code
- a, b  in  LEN  operands
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- response  out  LEN  registered result
- flgs  out  4  registered {N,Z,C,V}

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 MUL (low LEN bits), 3 OR, 4 AND, 5 XOR
  - 6 LSL, 7 LSR, 8 ROR, 9 ASR, 10 ROL
  - 11 CMP: SUB flags, response = a unchanged
  - 12-15 reserved: response 0, flgs 4'b0100
- Shift/rotate amount = b[SHW-1:0], range 0..LEN-1. Amount 0: response = a, C = 0.
- Flags:
  - N = response[LEN-1]; Z = (response == 0).
  - ADD: C = carry out of bit LEN-1; V = signed overflow.
  - SUB/CMP: C = 1 when no borrow (a ≥ b unsigned); V = signed overflow.
  - MUL (unsigned): C = V = (high LEN bits of 2·LEN product ≠ 0).
  - Logic ops: C = V = 0.
  - LSL/LSR/ASR: C = last bit shifted out; V = 0.
  - ROR: C = response[LEN-1]; ROL: C = response[0]; V = 0.
- States:
  - IDLE: in_ready = 1; out_valid = 0.
  - BUSY: multiply in progress; in_ready = 0.
  - DONE: out_valid = 1; in_ready = 0.
- Transitions:
  - IDLE→DONE on accept of a non-MUL op. Result is computed combinationally from the request and registered at the accepting edge.
  - IDLE→BUSY on accept of MUL. a, b and opcd are latched. A radix-2 shift-add runs one bit per cycle, LEN iterations, with a 2·LEN accumulator.
  - BUSY→DONE after the LEN-th iteration. Flags are computed from the full product.
  - DONE→IDLE on out_ready (out_valid is 1 in DONE). response/flgs keep their last values in IDLE but are not valid.
- Operands and opcd are ignored unless in_valid && in_ready. Changing a/b during BUSY has no effect.
- No overlap: a new request cannot be accepted in the same cycle a result is consumed.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, in_ready 1, out_valid 0, response 0, flgs 0, multiplier accumulator and counter 0. Effective immediately, no clock required.
- Reset mid-operation aborts: a multiply in BUSY or an unconsumed result in DONE is discarded. First accept is possible on the first rising edge after rst_n rises.
- Non-MUL latency: accept at edge k → out_valid high after edge k.
- MUL latency: accept at edge k → out_valid high after edge k+LEN (32 cycles at LEN=32).
- Back-pressure: out_valid, response and flgs remain stable while out_ready is 0, for any number of cycles.
- Throughput:
  - One op per 2 cycles when out_ready is held 1 and ops are single-cycle (IDLE, DONE).
  - One MUL per LEN+2 cycles.
- in_ready is a pure function of state, with no combinational path from in_valid or out_ready.

## Test plan
- Reset, then accept ADD, a=2, b=2 → next cycle out_valid=1, response=4, flgs=0000. Then ADD a=0xFFFFFFFF, b=0x10000000 → response=0x0FFFFFFF, flgs=0010 (C=1).
- SUB a=7, b=6 → response=1, flgs=0010. CMP a=5, b=5 → response=5, flgs=0110. SUB a=0, b=1 → 0xFFFFFFFF, flgs=1000.
- MUL a=3, b=2 → out_valid exactly 32 cycles after accept, response=6, flgs=0000, in_ready=0 throughout. MUL a=0x10000, b=0x10000 → response=0, flgs=0111.
- Shifts with b=2:
  - LSL a=3 → 0xC, C=0; LSR a=3 → 0, flgs=0110.
  - ROR a=2 → 0x80000000, flgs=1010.
  - ASR a=0x80000000 → 0xE0000000, flgs=1000.
  - ROL b=0, a=9 → 9, C=0.
- Hold out_ready=0 for 10 cycles after a result: response/flgs stable, in_ready=0, new in_valid requests ignored. Raise out_ready → IDLE next cycle.
- Assert rst_n=0 asynchronously at cycle 10 of a MUL: outputs return to reset values immediately. After release, ADD a=1, b=1 → response=2 with no residue from the aborted MUL.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a held result port.
// Single-cycle ops are registered at the accepting edge. MUL is a radix-2
// shift-add that runs for LEN cycles.
module alu_seq #(
  parameter int unsigned LEN = 32,
  parameter int unsigned SHW = $clog2(LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     opcd,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] response,
  output logic [3:0]     flgs
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ROR = 4'd8,
    OP_ASR = 4'd9,
    OP_ROL = 4'd10,
    OP_CMP = 4'd11
  } op_e;

  localparam int unsigned MSB = LEN - 1;

  state_e             state_q;
  logic [LEN-1:0]     response_q;
  logic [3:0]         flgs_q;
  logic [2*LEN-1:0]   mcand_q;
  logic [LEN-1:0]     mplier_q;
  logic [2*LEN-1:0]   acc_q;
  logic [2*LEN-1:0]   acc_d;
  logic [SHW-1:0]     cnt_q;

  logic [SHW-1:0]     shamt;
  logic [LEN:0]       add_w;
  logic [LEN:0]       sub_w;
  logic [LEN:0]       lsl_w;
  logic [LEN:0]       lsr_w;
  logic [LEN:0]       asr_w;
  logic [2*LEN-1:0]   ror_w;
  logic [2*LEN-1:0]   rol_w;
  logic [LEN-1:0]     alu_res;
  logic [LEN-1:0]     flag_src;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flg;
  logic [LEN-1:0]     prod_hi;
  logic [LEN-1:0]     prod_lo;
  logic               prod_ovf;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign response  = response_q;
  assign flgs      = flgs_q;

  // Single-cycle datapath: result and flags straight from the request operands.
  // Shifts are done one bit wider so the last bit shifted out lands in the spare
  // bit, which is 0 when the amount is 0.
  always_comb begin
    shamt    = b[SHW-1:0];
    add_w    = {1'b0, a} + {1'b0, b};
    sub_w    = {1'b0, a} - {1'b0, b};
    lsl_w    = {1'b0, a} << shamt;
    lsr_w    = {a, 1'b0} >> shamt;
    asr_w    = $unsigned($signed({a, 1'b0}) >>> shamt);
    ror_w    = {a, a} >> shamt;
    rol_w    = {a, a} << shamt;
    alu_res  = '0;
    flag_src = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (opcd)
      OP_ADD: begin
        alu_res  = add_w[LEN-1:0];
        flag_src = alu_res;
        alu_c    = add_w[LEN];
        alu_v    = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res  = sub_w[LEN-1:0];
        flag_src = alu_res;
        alu_c    = ~sub_w[LEN];
        alu_v    = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      // CMP reports the difference's flags while passing a through.
      OP_CMP: begin
        alu_res  = a;
        flag_src = sub_w[LEN-1:0];
        alu_c    = ~sub_w[LEN];
        alu_v    = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_OR: begin
        alu_res  = a | b;
        flag_src = alu_res;
      end
      OP_AND: begin
        alu_res  = a & b;
        flag_src = alu_res;
      end
      OP_XOR: begin
        alu_res  = a ^ b;
        flag_src = alu_res;
      end
      OP_LSL: begin
        alu_res  = lsl_w[LEN-1:0];
        flag_src = alu_res;
        alu_c    = lsl_w[LEN];
      end
      OP_LSR: begin
        alu_res  = lsr_w[LEN:1];
        flag_src = alu_res;
        alu_c    = lsr_w[0];
      end
      OP_ASR: begin
        alu_res  = asr_w[LEN:1];
        flag_src = alu_res;
        alu_c    = asr_w[0];
      end
      OP_ROR: begin
        alu_res  = ror_w[LEN-1:0];
        flag_src = alu_res;
        alu_c    = (shamt != '0) && ror_w[MSB];
      end
      OP_ROL: begin
        alu_res  = rol_w[2*LEN-1:LEN];
        flag_src = alu_res;
        alu_c    = (shamt != '0) && rol_w[LEN];
      end
      // Reserved codes (and MUL, which never uses this path) give 0 with
      // only Z set.
      default: begin
        alu_res  = '0;
        flag_src = '0;
      end
    endcase
    alu_flg = {flag_src[MSB], (flag_src == '0), alu_c, alu_v};
  end

  // Multiplier step: the accumulator value after the current iteration, so the
  // final product can be registered on the LEN-th BUSY edge.
  always_comb begin
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_hi  = acc_d[2*LEN-1:LEN];
    prod_lo  = acc_d[LEN-1:0];
    prod_ovf = (prod_hi != '0);
  end

  // Control FSM with the registered result, flags and multiplier state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      response_q <= '0;
      flgs_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (opcd == OP_MUL) begin
              mcand_q  <= {{LEN{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_BUSY;
            end else begin
              response_q <= alu_res;
              flgs_q     <= alu_flg;
              state_q    <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SHW'(LEN - 1)) begin
            response_q <= prod_lo;
            flgs_q     <= {prod_lo[MSB], (prod_lo == '0), prod_ovf, prod_ovf};
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
